// File: rtl/fpu_addsub_arbiter_if.sv
// Bundle of the requester, FPU and response signals of the shared add/sub
// arbiter. The slave modport is the arbiter's view; master is the environment.
interface fpu_addsub_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int NUM_OP  = 1,
  parameter int ID_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) ();
  logic [NUM_REQ-1:0]        i_req_valid;
  logic [NUM_REQ-1:0]        o_req_ready;
  logic [NUM_REQ*NUM_OP-1:0] i_req_op;
  logic [NUM_REQ*32-1:0]     i_req_a;
  logic [NUM_REQ*32-1:0]     i_req_b;
  logic [NUM_OP-1:0]         o_fpu_op;
  logic [31:0]               o_fpu_a;
  logic [31:0]               o_fpu_b;
  logic [31:0]               i_fpu_s;
  logic                      i_fpu_ov;
  logic                      i_fpu_un;
  logic                      o_rsp_valid;
  logic                      i_rsp_ready;
  logic [ID_W-1:0]           o_rsp_id;
  logic [31:0]               o_rsp_data;
  logic                      o_rsp_ov;
  logic                      o_rsp_un;
  logic                      o_busy;

  modport slave (
    input  i_req_valid, i_req_op, i_req_a, i_req_b,
    input  i_fpu_s, i_fpu_ov, i_fpu_un, i_rsp_ready,
    output o_req_ready, o_fpu_op, o_fpu_a, o_fpu_b,
    output o_rsp_valid, o_rsp_id, o_rsp_data, o_rsp_ov, o_rsp_un, o_busy
  );

  modport master (
    output i_req_valid, i_req_op, i_req_a, i_req_b,
    output i_fpu_s, i_fpu_ov, i_fpu_un, i_rsp_ready,
    input  o_req_ready, o_fpu_op, o_fpu_a, o_fpu_b,
    input  o_rsp_valid, o_rsp_id, o_rsp_data, o_rsp_ov, o_rsp_un, o_busy
  );
endinterface

// File: rtl/fpu_addsub_arbiter.sv
// Round-robin arbiter sharing one combinational FPU add/sub unit among
// NUM_REQ requesters. One operation in flight: grant/capture (IDLE), FPU
// evaluation (EXEC), registered response held until accepted (RESP).
module fpu_addsub_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int NUM_OP  = 1,
  parameter int ID_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  fpu_addsub_arbiter_if.slave bus
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t              state_q, state_d;
  logic [ID_W-1:0]     rr_q, rr_d;
  logic [ID_W-1:0]     id_q, id_d;
  logic [NUM_OP-1:0]   op_q, op_d;
  logic [31:0]         a_q, a_d;
  logic [31:0]         b_q, b_d;
  logic [31:0]         data_q, data_d;
  logic                ov_q, ov_d;
  logic                un_q, un_d;
  logic                vld_q, vld_d;

  logic                hi_found, lo_found;
  logic [ID_W-1:0]     hi_idx, lo_idx, gnt_idx;
  logic [NUM_REQ-1:0]  gnt_oh;
  logic [NUM_REQ-1:0]  req_ready;
  logic [NUM_OP-1:0]   op_sel;
  logic [31:0]         a_sel, b_sel;

  // Round-robin search: lowest valid index at or above the pointer,
  // otherwise wrap to the lowest valid index overall.
  always_comb begin
    hi_found = 1'b0;
    lo_found = 1'b0;
    hi_idx   = '0;
    lo_idx   = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (bus.i_req_valid[k]) begin
        lo_found = 1'b1;
        lo_idx   = ID_W'(k);
        if (ID_W'(k) >= rr_q) begin
          hi_found = 1'b1;
          hi_idx   = ID_W'(k);
        end
      end
    end
    gnt_idx = hi_found ? hi_idx : lo_idx;
  end

  // One-hot grant and operand mux for the winning requester.
  always_comb begin
    gnt_oh = '0;
    op_sel = '0;
    a_sel  = '0;
    b_sel  = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (lo_found && (gnt_idx == ID_W'(k))) begin
        gnt_oh[k] = 1'b1;
        op_sel    = bus.i_req_op[k*NUM_OP +: NUM_OP];
        a_sel     = bus.i_req_a[k*32 +: 32];
        b_sel     = bus.i_req_b[k*32 +: 32];
      end
    end
  end

  // Next-state and register-update logic; ready only offered in IDLE.
  always_comb begin
    state_d   = state_q;
    rr_d      = rr_q;
    id_d      = id_q;
    op_d      = op_q;
    a_d       = a_q;
    b_d       = b_q;
    data_d    = data_q;
    ov_d      = ov_q;
    un_d      = un_q;
    vld_d     = vld_q;
    req_ready = '0;
    case (state_q)
      IDLE: begin
        if (lo_found) begin
          req_ready = gnt_oh;
          op_d      = op_sel;
          a_d       = a_sel;
          b_d       = b_sel;
          id_d      = gnt_idx;
          state_d   = EXEC;
        end
      end
      EXEC: begin
        data_d  = bus.i_fpu_s;
        ov_d    = bus.i_fpu_ov;
        un_d    = bus.i_fpu_un;
        vld_d   = 1'b1;
        state_d = RESP;
      end
      RESP: begin
        if (bus.i_rsp_ready) begin
          vld_d   = 1'b0;
          rr_d    = (id_q == ID_W'(NUM_REQ - 1)) ? '0 : id_q + ID_W'(1);
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State, pointer, operand and response registers; all cleared on reset.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= IDLE;
      rr_q    <= '0;
      id_q    <= '0;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      data_q  <= '0;
      ov_q    <= 1'b0;
      un_q    <= 1'b0;
      vld_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      id_q    <= id_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      data_q  <= data_d;
      ov_q    <= ov_d;
      un_q    <= un_d;
      vld_q   <= vld_d;
    end
  end

  // Ready is forced low while reset is held, independent of the clock.
  assign bus.o_req_ready = req_ready & {NUM_REQ{i_rst_n}};
  assign bus.o_fpu_op    = op_q;
  assign bus.o_fpu_a     = a_q;
  assign bus.o_fpu_b     = b_q;
  assign bus.o_rsp_valid = vld_q;
  assign bus.o_rsp_id    = id_q;
  assign bus.o_rsp_data  = data_q;
  assign bus.o_rsp_ov    = ov_q;
  assign bus.o_rsp_un    = un_q;
  assign bus.o_busy      = (state_q != IDLE);

endmodule

// File: doc/fpu_addsub_arbiter.md
Name: fpu_addsub_arbiter

Overview:
- Shares one combinational FPU add/sub datapath (32-bit single-precision, i_add_sub/i_32_a/i_32_b in, o_32_s/o_ov_flag/o_un_flag out) among NUM_REQ requesters.
- Round-robin grant, operand capture, one-cycle datapath evaluation, registered result.
- Result returned with the requester ID over a valid/ready response channel.
- Sits between issuing agents (sequencers, DMA-driven kernels) and the shared FPU instance.

Parameters:
- NUM_REQ, 4, number of requesters (2..16).
- NUM_OP, 1, width of the op field, passed unchanged to FPU i_add_sub.
- ID_W, $clog2(NUM_REQ), width of the response ID (min 1).

Ports:
- i_clk  in  1  clock.
- i_rst_n  in  1  reset.
- i_req_valid  in  NUM_REQ  per-requester request valid.
- o_req_ready  out  NUM_REQ  per-requester accept; at most one bit high.
- i_req_op  in  NUM_REQ*NUM_OP  op field; requester k at [k*NUM_OP +: NUM_OP].
- i_req_a  in  NUM_REQ*32  operand A; requester k at [k*32 +: 32].
- i_req_b  in  NUM_REQ*32  operand B; same packing as i_req_a.
- o_fpu_op  out  NUM_OP  to FPU i_add_sub.
- o_fpu_a  out  32  to FPU i_32_a.
- o_fpu_b  out  32  to FPU i_32_b.
- i_fpu_s  in  32  from FPU o_32_s.
- i_fpu_ov  in  1  from FPU o_ov_flag.
- i_fpu_un  in  1  from FPU o_un_flag.
- o_rsp_valid  out  1  response valid.
- i_rsp_ready  in  1  response accept.
- o_rsp_id  out  ID_W  index of the requester that owns the response.
- o_rsp_data  out  32  result.
- o_rsp_ov  out  1  overflow flag of the result.
- o_rsp_un  out  1  underflow flag of the result.
- o_busy  out  1  high whenever state != IDLE.

Behaviour:
- Clocking/reset (already decided): one clock i_clk; i_rst_n is asynchronous and active-low.
- Reset values:
  - state=IDLE, rr pointer=0.
  - Operand regs (o_fpu_op/a/b)=0.
  - o_rsp_valid=0, o_rsp_id=0, o_rsp_data=0, o_rsp_ov=0, o_rsp_un=0, o_busy=0.
  - o_req_ready=0 while i_rst_n low.
- FSM states IDLE, EXEC, RESP.
- IDLE:
  - Grant g = first k with i_req_valid[k]=1, searching from the rr pointer upward, wrapping NUM_REQ-1 -> 0.
  - o_req_ready[g]=1 combinationally in the same cycle; all other ready bits 0.
  - On valid&ready: register op/a/b of g into the operand regs, record g as the ID, go to EXEC.
  - No valid: stay in IDLE; outputs hold their values.
- EXEC:
  - Operand regs drive the FPU (combinational path).
  - At the clock edge: capture i_fpu_s/ov/un into o_rsp_data/ov/un, set o_rsp_valid=1, go to RESP.
- RESP:
  - Hold o_rsp_* stable while i_rsp_ready=0 (no limit on stall length).
  - On i_rsp_ready=1: o_rsp_valid=0 next cycle, rr pointer=(ID+1) mod NUM_REQ, go to IDLE.
  - No new grant in the same cycle as the response handshake.
- o_req_ready is 0 in EXEC and RESP.
- Latency: handshake in cycle T -> o_rsp_valid=1 in cycle T+2. Minimum 3 cycles per operation.
- Requesters may drop or change i_req_valid before receiving ready; no state is kept for unaccepted requests.
- Operand regs are not cleared after an operation; the FPU inputs keep the last operands.
- Round-robin guarantee: a continuously valid requester is granted within NUM_REQ grants.
- Reset asserted mid-operation (EXEC/RESP): asynchronous return to reset values; the in-flight result is dropped and no response is issued.
- i_rsp_ready high while o_rsp_valid=0: ignored.

Test Plan:
- Single request on requester 2 (a=0x3F800000, b=0x40000000); FPU stub returns a+b=0x40400000 with ov=0, un=0 -> o_req_ready=4'b0100 in the handshake cycle; o_rsp_valid at T+2 with id=2, data=0x40400000.
- All 4 requesters held valid from reset -> grant order 0,1,2,3,0; each response id matches that order; ready never has more than one bit high.
- Back-pressure: i_rsp_ready=0 for 10 cycles in RESP -> o_rsp_data/id/ov/un stable; o_req_ready=0; o_busy=1; release -> one response only, then IDLE.
- Flag pass-through: stub drives ov=1, un=1 in EXEC -> o_rsp_ov=1 and o_rsp_un=1 in the response; next operation with ov=0 clears them.
- i_rst_n pulsed low in RESP -> o_rsp_valid=0 and o_busy=0 immediately, with no clock edge; after release the first grant goes to the lowest valid index (rr pointer=0).
- Requester 3 drops i_req_valid while requester 1 is being served -> no response with id=3; next grant goes to the next valid index after 1.
